// File: rtl/ocx_tlx_flit_run_tracker.sv
// ============================================================================
// Module   : ocx_tlx_flit_run_tracker
// Purpose  : Classifies received TLX flits as control or data from the
//            declared run length; emits registered control/data/bookend
//            strobes and masked BDI bits for the run just closed.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ocx_tlx_flit_run_tracker #(
   parameter int max_run_length = 8,
   parameter int err_sticky     = 1
) (
   input  logic       tlx_clk,
   input  logic       reset_n,
   input  logic       rx_flit_v,
   input  logic [3:0] rx_ctl_run_length,
   input  logic [7:0] rx_ctl_bdi,
   input  logic       crc_error,
   input  logic       rx_resync,
   output logic       ctl_flit_start,
   output logic [3:0] run_length,
   output logic       bookend_flit_v,
   output logic [7:0] bad_data_indicator,
   output logic       data_flit_v,
   output logic [2:0] data_flit_idx,
   output logic       run_active,
   output logic       protocol_error
);

   localparam logic [1:0] ST_EXPECT_CTL = 2'd0;
   localparam logic [1:0] ST_DATA       = 2'd1;
   localparam logic [1:0] ST_HALT       = 2'd2;

   localparam logic [3:0] c_max_rl = 4'(max_run_length);

   logic [1:0] r_state;
   logic [1:0] w_state_d;
   logic [3:0] cnt_q;
   logic [3:0] prev_run_q;
   logic [3:0] rl_q;
   logic [3:0] w_cnt_d;
   logic [3:0] w_prev_run_d;
   logic [3:0] w_rl_d;

   logic       w_ctl_start_d;
   logic [3:0] w_run_length_d;
   logic       w_bookend_d;
   logic [7:0] w_bdi_d;
   logic       w_data_v_d;
   logic [2:0] w_data_idx_d;
   logic       w_run_active_d;
   logic       w_protocol_error_d;
   logic [7:0] w_prev_mask;

   // Mask covers the low prev_run_q bits; computed one bit wider so 8 gives 8'hFF
   assign w_prev_mask = 8'((9'd1 << prev_run_q) - 9'd1);

   // State and datapath registers
   always_ff @(posedge tlx_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state            <= ST_EXPECT_CTL;
         cnt_q              <= 4'd0;
         prev_run_q         <= 4'd0;
         rl_q               <= 4'd0;
         ctl_flit_start     <= 1'b0;
         run_length         <= 4'd0;
         bookend_flit_v     <= 1'b0;
         bad_data_indicator <= 8'd0;
         data_flit_v        <= 1'b0;
         data_flit_idx      <= 3'd0;
         run_active         <= 1'b0;
         protocol_error     <= 1'b0;
      end else begin
         r_state            <= w_state_d;
         cnt_q              <= w_cnt_d;
         prev_run_q         <= w_prev_run_d;
         rl_q               <= w_rl_d;
         ctl_flit_start     <= w_ctl_start_d;
         run_length         <= w_run_length_d;
         bookend_flit_v     <= w_bookend_d;
         bad_data_indicator <= w_bdi_d;
         data_flit_v        <= w_data_v_d;
         data_flit_idx      <= w_data_idx_d;
         run_active         <= w_run_active_d;
         protocol_error     <= w_protocol_error_d;
      end
   end

   // Next-state and internal counters; crc_error outranks resync outranks flits
   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = cnt_q;
      w_prev_run_d = prev_run_q;
      w_rl_d       = rl_q;
      if (crc_error) begin
         w_state_d    = ST_HALT;
         w_cnt_d      = 4'd0;
         w_prev_run_d = 4'd0;
      end else if (rx_resync) begin
         w_state_d    = ST_EXPECT_CTL;
         w_cnt_d      = 4'd0;
         w_prev_run_d = 4'd0;
      end else if (rx_flit_v) begin
         case (r_state)
            ST_EXPECT_CTL: begin
               if (rx_ctl_run_length > c_max_rl) begin
                  w_state_d = ST_HALT;
               end else if (rx_ctl_run_length == 4'd0) begin
                  w_prev_run_d = 4'd0;
               end else begin
                  w_cnt_d   = rx_ctl_run_length;
                  w_rl_d    = rx_ctl_run_length;
                  w_state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               w_cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  w_state_d    = ST_EXPECT_CTL;
                  w_prev_run_d = rl_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Next values for the registered outputs
   always_comb begin
      w_ctl_start_d      = 1'b0;
      w_run_length_d     = run_length;
      w_bookend_d        = 1'b0;
      w_bdi_d            = 8'd0;
      w_data_v_d         = 1'b0;
      w_data_idx_d       = data_flit_idx;
      w_protocol_error_d = protocol_error;
      if (!crc_error && rx_resync) begin
         if (err_sticky == 0) begin
            w_protocol_error_d = 1'b0;
         end
      end else if (!crc_error && rx_flit_v) begin
         case (r_state)
            ST_EXPECT_CTL: begin
               w_ctl_start_d  = 1'b1;
               w_run_length_d = rx_ctl_run_length;
               if (prev_run_q != 4'd0) begin
                  w_bookend_d = 1'b1;
                  w_bdi_d     = rx_ctl_bdi & w_prev_mask;
               end
               if (rx_ctl_run_length > c_max_rl) begin
                  w_protocol_error_d = 1'b1;
               end
            end
            ST_DATA: begin
               w_data_v_d   = 1'b1;
               w_data_idx_d = 3'(rl_q - cnt_q);
            end
            default: ;
         endcase
      end
      // Stretch through the last data strobe so the run reads as one window
      w_run_active_d = (w_state_d == ST_DATA) | w_data_v_d;
   end

endmodule

`default_nettype wire

// File: tb/tb_ocx_tlx_flit_run_tracker.sv
// ============================================================================
// Module   : tb_ocx_tlx_flit_run_tracker
// Purpose  : Directed scoreboard bench for ocx_tlx_flit_run_tracker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ocx_tlx_flit_run_tracker;

   typedef struct packed {
      int unsigned cyc;
      logic        ctl;
      logic        dat;
      logic [2:0]  idx;
      logic [3:0]  rl;
      logic        book;
      logic [7:0]  bdi;
      logic        act;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx_flit_v;
   logic [3:0] rx_ctl_run_length;
   logic [7:0] rx_ctl_bdi;
   logic       crc_error;
   logic       rx_resync;

   logic       ctl_flit_start;
   logic [3:0] run_length;
   logic       bookend_flit_v;
   logic [7:0] bad_data_indicator;
   logic       data_flit_v;
   logic [2:0] data_flit_idx;
   logic       run_active;
   logic       protocol_error;

   logic       ns_ctl_flit_start;
   logic [3:0] ns_run_length;
   logic       ns_bookend_flit_v;
   logic [7:0] ns_bad_data_indicator;
   logic       ns_data_flit_v;
   logic [2:0] ns_data_flit_idx;
   logic       ns_run_active;
   logic       ns_protocol_error;

   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ocx_tlx_flit_run_tracker #(.max_run_length(8), .err_sticky(1)) u_dut (
      .tlx_clk            (clk),
      .reset_n            (reset_n),
      .rx_flit_v          (rx_flit_v),
      .rx_ctl_run_length  (rx_ctl_run_length),
      .rx_ctl_bdi         (rx_ctl_bdi),
      .crc_error          (crc_error),
      .rx_resync          (rx_resync),
      .ctl_flit_start     (ctl_flit_start),
      .run_length         (run_length),
      .bookend_flit_v     (bookend_flit_v),
      .bad_data_indicator (bad_data_indicator),
      .data_flit_v        (data_flit_v),
      .data_flit_idx      (data_flit_idx),
      .run_active         (run_active),
      .protocol_error     (protocol_error)
   );

   ocx_tlx_flit_run_tracker #(.max_run_length(8), .err_sticky(0)) u_dut_ns (
      .tlx_clk            (clk),
      .reset_n            (reset_n),
      .rx_flit_v          (rx_flit_v),
      .rx_ctl_run_length  (rx_ctl_run_length),
      .rx_ctl_bdi         (rx_ctl_bdi),
      .crc_error          (crc_error),
      .rx_resync          (rx_resync),
      .ctl_flit_start     (ns_ctl_flit_start),
      .run_length         (ns_run_length),
      .bookend_flit_v     (ns_bookend_flit_v),
      .bad_data_indicator (ns_bad_data_indicator),
      .data_flit_v        (ns_data_flit_v),
      .data_flit_idx      (ns_data_flit_idx),
      .run_active         (ns_run_active),
      .protocol_error     (ns_protocol_error)
   );

   // Monitor: every strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (reset_n && (ctl_flit_start || data_flit_v)) begin
         exp_t e;
         exp_t g;
         n_tests++;
         g = '{cyc: cyc, ctl: ctl_flit_start, dat: data_flit_v,
               idx: (data_flit_v ? data_flit_idx : 3'd0), rl: run_length,
               book: bookend_flit_v, bdi: bad_data_indicator, act: run_active};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got %h, required no strobe", g);
         end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL strobe: got cyc=%0d ctl=%b dat=%b idx=%0d rl=%0d book=%b bdi=%h act=%b, required cyc=%0d ctl=%b dat=%b idx=%0d rl=%0d book=%b bdi=%h act=%b",
                        g.cyc, g.ctl, g.dat, g.idx, g.rl, g.book, g.bdi, g.act,
                        e.cyc, e.ctl, e.dat, e.idx, e.rl, e.book, e.bdi, e.act);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] rl, input logic [7:0] bdi,
                        input logic crc, input logic rs);
      rx_flit_v         = v;
      rx_ctl_run_length = rl;
      rx_ctl_bdi        = bdi;
      crc_error         = crc;
      rx_resync         = rs;
      @(posedge clk);
      #1;
      rx_flit_v = 1'b0;
      crc_error = 1'b0;
      rx_resync = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic exp_ctl(input logic [3:0] rl, input logic [7:0] bdi_in,
                          input logic book, input logic [7:0] ebdi, input logic act);
      exp_q.push_back('{cyc: cyc + 1, ctl: 1'b1, dat: 1'b0, idx: 3'd0, rl: rl,
                        book: book, bdi: ebdi, act: act});
      drive(1'b1, rl, bdi_in, 1'b0, 1'b0);
   endtask

   // Header fields carry junk on data flits; the DUT must ignore them
   task automatic exp_dat(input logic [2:0] idx, input logic [3:0] rl, input logic act);
      exp_q.push_back('{cyc: cyc + 1, ctl: 1'b0, dat: 1'b1, idx: idx, rl: rl,
                        book: 1'b0, bdi: 8'd0, act: act});
      drive(1'b1, 4'hF, 8'hFF, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n           = 1'b0;
      rx_flit_v         = 1'b0;
      rx_ctl_run_length = 4'd0;
      rx_ctl_bdi        = 8'd0;
      crc_error         = 1'b0;
      rx_resync         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({ctl_flit_start, run_length, bookend_flit_v, bad_data_indicator,
                                data_flit_v, data_flit_idx, run_active, protocol_error}), 32'd0);
      reset_n = 1'b1;

      // rl=3 run closed by rl=0 control flit
      exp_ctl(4'd3, 8'h00, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) exp_dat(3'(i), 4'd3, 1'b1);
      exp_ctl(4'd0, 8'hFF, 1'b1, 8'h07, 1'b0);

      // Maximum run, back to back
      exp_ctl(4'd8, 8'h00, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++) exp_dat(3'(i), 4'd8, 1'b1);
      exp_ctl(4'd0, 8'hA5, 1'b1, 8'hA5, 1'b0);

      // CRC error mid-run
      exp_ctl(4'd2, 8'h00, 1'b0, 8'h00, 1'b1);
      exp_dat(3'd0, 4'd2, 1'b1);
      drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
      chk("run_active_after_crc", 32'(run_active), 32'd0);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'd1, 8'hFF, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
      exp_ctl(4'd0, 8'hFF, 1'b0, 8'h00, 1'b0);

      // crc beats resync and flit; resync drops its own flit
      exp_ctl(4'd1, 8'h00, 1'b0, 8'h00, 1'b1);
      drive(1'b1, 4'd1, 8'hFF, 1'b1, 1'b1);
      drive(1'b1, 4'd2, 8'hFF, 1'b0, 1'b1);
      exp_ctl(4'd0, 8'hFF, 1'b0, 8'h00, 1'b0);

      // Illegal run length
      exp_ctl(4'd9, 8'hFF, 1'b0, 8'h00, 1'b0);
      chk("perr_set_sticky", 32'(protocol_error), 32'd1);
      chk("perr_set_nonsticky", 32'(ns_protocol_error), 32'd1);
      drive(1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
      chk("perr_after_resync_sticky", 32'(protocol_error), 32'd1);
      chk("perr_after_resync_nonsticky", 32'(ns_protocol_error), 32'd0);

      // Gapped rl=4 run
      exp_ctl(4'd4, 8'h00, 1'b0, 8'h00, 1'b1);
      idle();
      chk("run_active_gap0", 32'(run_active), 32'd1);
      exp_dat(3'd0, 4'd4, 1'b1);
      idle();
      idle();
      chk("run_active_gap1", 32'(run_active), 32'd1);
      exp_dat(3'd1, 4'd4, 1'b1);
      idle();
      exp_dat(3'd2, 4'd4, 1'b1);
      exp_dat(3'd3, 4'd4, 1'b1);
      idle();
      chk("run_active_after_run", 32'(run_active), 32'd0);

      // Bookend of the rl=4 run masks to the low 4 bits, then reset mid-run
      exp_ctl(4'd3, 8'h3C, 1'b1, 8'h0C, 1'b1);
      exp_dat(3'd0, 4'd3, 1'b1);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({ctl_flit_start, run_length, bookend_flit_v, bad_data_indicator,
                                      data_flit_v, data_flit_idx, run_active, protocol_error}), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      exp_ctl(4'd0, 8'hFF, 1'b0, 8'h00, 1'b0);
      idle();
      idle();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
